sap_core_param: RTL

- Parametrised successor to the SAP-1 top level: one self-contained accumulator processor with internal program/data RAM, PC, MAR, IR, accumulator, B register, add/sub ALU, output register and T-state sequencer.
- Extends SAP-1 with:
  - generic data width and memory depth;
  - STA, LDI and JMP/JC/JZ instructions, with carry and zero flags;
  - a program-load port.
- Sits as the system top; the program is loaded through the load port, then run via run_prog.

---
 rtl/sap_core_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sap_core_param.sv
// Parametrised SAP-style accumulator processor: internal RAM, six T-state sequencer,
// ALU with carry/zero flags, program-load port and output register.
module sap_core_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              nclr,
  input  logic              run_prog,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  output logic [WIDTH-1:0]  result,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic              carry,
  output logic              zero,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpLdi = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJc  = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4, StT5, StT6, StHalt} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [WIDTH-1:0]    r_ir;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_result;
  logic                r_carry;
  logic                r_zero;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_ram [Depth];

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [WIDTH-1:0]    w_imm;
  logic [WIDTH-1:0]    w_ram_rd;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_diff;
  logic                w_load_ok;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_waddr;
  logic [WIDTH-1:0]    w_ram_wdata;

  assign w_op      = r_ir[WIDTH-1 -: 4];
  assign w_op_addr = r_ir[ADDR_W-1:0];
  assign w_imm     = {4'b0000, r_ir[WIDTH-5:0]};
  assign w_ram_rd  = r_ram[r_mar];
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

  // Load port shares the single write port with STA; nclr gating kills any write under reset.
  assign w_load_ok   = (r_state == StIdle) || (r_state == StHalt);
  assign w_ram_we    = nclr && ((w_load_ok && prog_we) || (r_state == StT5 && w_op == OpSta));
  assign w_ram_waddr = w_load_ok ? prog_addr : r_mar;
  assign w_ram_wdata = w_load_ok ? prog_data : r_a;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_waddr] <= w_ram_wdata;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (run_prog) w_state_next = StT1;
      StT1:    w_state_next = StT2;
      StT2:    w_state_next = StT3;
      StT3:    w_state_next = StT4;
      StT4:    w_state_next = (w_op == OpHlt) ? StHalt : StT5;
      StT5:    w_state_next = StT6;
      StT6:    w_state_next = run_prog ? StT1 : StIdle;
      StHalt:  if (!run_prog) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        StIdle: if (run_prog) r_pc <= '0;
        StT1:   r_mar <= r_pc;
        StT2:   r_pc <= r_pc + ADDR_W'(1);
        StT3:   r_ir <= w_ram_rd;
        StT4: begin
          case (w_op)
            OpLda, OpAdd, OpSub, OpSta: r_mar <= w_op_addr;
            OpLdi: begin
              r_a    <= w_imm;
              r_zero <= (w_imm == '0);
            end
            OpJmp: r_pc <= w_op_addr;
            OpJc:  if (r_carry) r_pc <= w_op_addr;
            OpJz:  if (r_zero) r_pc <= w_op_addr;
            OpOut: begin
              r_result    <= r_a;
              r_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          case (w_op)
            OpLda: begin
              r_a    <= w_ram_rd;
              r_zero <= (w_ram_rd == '0);
            end
            OpAdd, OpSub: r_b <= w_ram_rd;
            default: ;
          endcase
        end
        StT6: begin
          case (w_op)
            OpAdd: begin
              r_a     <= w_sum[WIDTH-1:0];
              r_carry <= w_sum[WIDTH];
              r_zero  <= (w_sum[WIDTH-1:0] == '0);
            end
            // Carry means "no borrow": the extra difference bit is set only when A < B.
            OpSub: begin
              r_a     <= w_diff[WIDTH-1:0];
              r_carry <= ~w_diff[WIDTH];
              r_zero  <= (w_diff[WIDTH-1:0] == '0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == StHalt);
  assign busy      = (r_state != StIdle) && (r_state != StHalt);
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign pc        = r_pc;

endmodule
